// File: rtl/noc_packet_injector.sv
// ----------------------------------------------------------------------------
// noc_packet_injector
//
// Host-side transmitter for the mesh Packet_in channel. It gathers payload
// bytes from a valid/ready source, together with a 13-bit routing header,
// into one packet of 13 + SLOTS*FILTER_WIDTH bits. Each packet is then
// launched with a 4-phase bundled-data req/ack handshake.
//
// Optional feature macro: INJECTOR_ACK_SYNC_EN
//   defined   : i_pkt_ack passes through a 2-flop synchronizer (mesh may be
//               clocked asynchronously to i_clk)
//   undefined : i_pkt_ack is used directly (mesh must share i_clk)
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_s_valid    source byte valid
//   o_s_ready    block accepts a byte this cycle (high only in FILL)
//   i_s_data     payload byte
//   i_s_last     byte is the last of the current packet (partial send)
//   i_s_hdr      routing header, sampled with the slot-0 byte
//   o_pkt_req    4-phase request toward the mesh
//   o_pkt_data   packet: [12:0] header, slot k at [13+k*FILTER_WIDTH +: FILTER_WIDTH]
//   i_pkt_ack    4-phase acknowledge from the mesh
//   o_busy       high in every state except FILL with no bytes collected
//   o_pkt_count  number of completed packets (wraps)
// ----------------------------------------------------------------------------
module noc_packet_injector #(
    parameter int unsigned FILTER_WIDTH = 8,
    parameter int unsigned SLOTS        = 5,
    parameter int unsigned WIDTH        = 13 + SLOTS * FILTER_WIDTH,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_s_valid,
    output logic                    o_s_ready,
    input  logic [FILTER_WIDTH-1:0] i_s_data,
    input  logic                    i_s_last,
    input  logic [12:0]             i_s_hdr,
    output logic                    o_pkt_req,
    output logic [WIDTH-1:0]        o_pkt_data,
    input  logic                    i_pkt_ack,
    output logic                    o_busy,
    output logic [CNT_WIDTH-1:0]    o_pkt_count
);

    localparam int unsigned CW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(SLOTS - 1);

    typedef enum logic [1:0] {
        StFill,
        StReq,
        StRel
    } state_e;

    state_e                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH-1:0]       r_pkt_data;
    logic                   r_pkt_req;
    logic [CNT_WIDTH-1:0]   r_pkt_count;
    // Set by reset so the drain pass through REL does not count as a packet.
    logic                   r_first;
    logic                   w_ack_s;
    logic [WIDTH-1:0]       w_fresh;

`ifdef INJECTOR_ACK_SYNC_EN
    logic r_ack_meta;
    logic r_ack_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack_meta <= 1'b0;
            r_ack_sync <= 1'b0;
        end else begin
            r_ack_meta <= i_pkt_ack;
            r_ack_sync <= r_ack_meta;
        end
    end

    assign w_ack_s = r_ack_sync;
`else
    assign w_ack_s = i_pkt_ack;
`endif

    // Slot-0 write: new header, first byte, and all later slots cleared so a
    // partial packet carries zeros beyond its last byte.
    always_comb begin
        w_fresh                   = '0;
        w_fresh[12:0]             = i_s_hdr;
        w_fresh[13+:FILTER_WIDTH] = i_s_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StRel;
            r_cnt       <= '0;
            r_pkt_data  <= '0;
            r_pkt_req   <= 1'b0;
            r_pkt_count <= '0;
            r_first     <= 1'b1;
        end else begin
            unique case (r_state)
                StFill: begin
                    if (i_s_valid) begin
                        if (r_cnt == '0) begin
                            r_pkt_data <= w_fresh;
                        end else begin
                            r_pkt_data[13 + int'(r_cnt) * FILTER_WIDTH +: FILTER_WIDTH] <= i_s_data;
                        end
                        if (r_cnt == LAST_SLOT || i_s_last) begin
                            r_state   <= StReq;
                            r_pkt_req <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                StReq: begin
                    if (w_ack_s) begin
                        r_state   <= StRel;
                        r_pkt_req <= 1'b0;
                    end
                end
                StRel: begin
                    if (!w_ack_s) begin
                        r_state <= StFill;
                        r_cnt   <= '0;
                        r_first <= 1'b0;
                        if (!r_first) begin
                            r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    r_state   <= StRel;
                    r_pkt_req <= 1'b0;
                end
            endcase
        end
    end

    assign o_s_ready   = (r_state == StFill);
    assign o_busy      = !((r_state == StFill) && (r_cnt == '0));
    assign o_pkt_req   = r_pkt_req;
    assign o_pkt_data  = r_pkt_data;
    assign o_pkt_count = r_pkt_count;

endmodule

// File: tb/tb_noc_packet_injector.sv
// ----------------------------------------------------------------------------
// tb_noc_packet_injector
//
// Directed bench for noc_packet_injector. The ack responder echoes pkt_req
// delayed by two clocks unless the override is enabled. The counter is built
// narrow here so its wrap can be reached in a few dozen packets.
// ----------------------------------------------------------------------------
module tb_noc_packet_injector;

    localparam int unsigned FW    = 8;
    localparam int unsigned SL    = 5;
    localparam int unsigned W     = 13 + SL * FW;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [FW-1:0]    s_data;
    logic             s_last;
    logic [12:0]      s_hdr;
    logic             pkt_req;
    logic [W-1:0]     pkt_data;
    logic             pkt_ack;
    logic             busy;
    logic [CNT_W-1:0] pkt_count;

    logic r_d1 = 1'b0;
    logic r_d2 = 1'b0;
    logic ack_ovr_en;
    logic ack_ovr_val;

    int n_checks = 0;
    int n_pass   = 0;

    noc_packet_injector #(
        .FILTER_WIDTH (FW),
        .SLOTS        (SL),
        .WIDTH        (W),
        .CNT_WIDTH    (CNT_W)
    ) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_s_valid   (s_valid),
        .o_s_ready   (s_ready),
        .i_s_data    (s_data),
        .i_s_last    (s_last),
        .i_s_hdr     (s_hdr),
        .o_pkt_req   (pkt_req),
        .o_pkt_data  (pkt_data),
        .i_pkt_ack   (pkt_ack),
        .o_busy      (busy),
        .o_pkt_count (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        r_d1 <= pkt_req;
        r_d2 <= r_d1;
    end

    assign pkt_ack = ack_ovr_en ? ack_ovr_val : r_d2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte and return just after the edge that accepted it.
    task automatic send_byte(input logic [FW-1:0] d, input logic last, input logic [12:0] hdr);
        int k;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        s_hdr   = hdr;
        k = 0;
        while (!s_ready && k < 100) begin
            tick();
            k++;
        end
        if (!s_ready) check("send_ready_timeout", 64'(s_ready), 64'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!s_ready && k < 100) begin
            tick();
            k++;
        end
        check(tag, 64'(s_ready), 64'd1);
    endtask

    logic [W-1:0] exp_data;

    initial begin
        rst         = 1'b1;
        s_valid     = 1'b0;
        s_data      = '0;
        s_last      = 1'b0;
        s_hdr       = '0;
        ack_ovr_en  = 1'b1;
        ack_ovr_val = 1'b1;

        // Reset with a stale high ack.
        tick();
        tick();
        check("rst_pkt_req", 64'(pkt_req), 64'd0);
        check("rst_pkt_data", 64'(pkt_data), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("drain_hold", 64'({s_ready, pkt_req}), 64'd0);
        end
        ack_ovr_val = 1'b0;
        check("drain_ready_lag", 64'(s_ready), 64'd0);
        wait_done("drain_exit");
        check("drain_count", 64'(pkt_count), 64'd0);
        check("drain_busy", 64'(busy), 64'd0);
        check("drain_no_req", 64'(pkt_req), 64'd0);

        // Reset while waiting in REQ: packet dropped, back to REL.
        send_byte(8'h99, 1'b1, 13'h0055);
        check("mid_req_up", 64'(pkt_req), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_req_drop", 64'(pkt_req), 64'd0);
        rst = 1'b0;
        check("mid_rst_ready", 64'(s_ready), 64'd0);
        check("mid_rst_count", 64'(pkt_count), 64'd0);
        ack_ovr_en = 1'b0;
        wait_done("mid_rst_exit");

        // Full 5-byte packet; header only sampled with slot 0.
        send_byte(8'h11, 1'b0, 13'h00A5);
        send_byte(8'h22, 1'b0, 13'h1FFF);
        send_byte(8'h33, 1'b0, 13'h1FFF);
        send_byte(8'h44, 1'b0, 13'h1FFF);
        send_byte(8'h55, 1'b0, 13'h1FFF);
        check("full_req", 64'(pkt_req), 64'd1);
        check("full_hdr", 64'(pkt_data[12:0]), 64'h0A5);
        check("full_payload", 64'(pkt_data[W-1:13]), 64'h55_4433_2211);
        check("full_ready_low", 64'(s_ready), 64'd0);
        wait_done("full_done");
        check("full_count", 64'(pkt_count), 64'd1);
        check("full_req_low", 64'(pkt_req), 64'd0);

        // Partial packet via s_last; stale slots from the last packet must clear.
        send_byte(8'hAA, 1'b0, 13'h01F0);
        check("part_busy", 64'(busy), 64'd1);
        check("part_ready", 64'(s_ready), 64'd1);
        send_byte(8'hBB, 1'b1, 13'h0000);
        exp_data = W'(13'h01F0) | (W'(16'hBBAA) << 13);
        check("part_req", 64'(pkt_req), 64'd1);
        check("part_data", 64'(pkt_data), 64'(exp_data));
        wait_done("part_done");
        check("part_count", 64'(pkt_count), 64'd2);

        // Ack held low for 20 cycles: request and data hold steady.
        ack_ovr_en  = 1'b1;
        ack_ovr_val = 1'b0;
        for (int i = 1; i <= 5; i++) send_byte(FW'(i), 1'b0, 13'h0123);
        exp_data = {40'h05_0403_0201, 13'h0123};
        for (int i = 0; i < 20; i++) begin
            check("hold_req", 64'(pkt_req), 64'd1);
            check("hold_data", 64'(pkt_data), 64'(exp_data));
            check("hold_ready", 64'(s_ready), 64'd0);
            tick();
        end
        ack_ovr_en = 1'b0;
        wait_done("hold_done");
        check("hold_count", 64'(pkt_count), 64'd3);

        // One-byte packets run the counter up to its wrap.
        for (int i = 0; i < 12; i++) begin
            send_byte(FW'(8'h40 + i), 1'b1, 13'h00FF);
            if (i == 0) begin
                exp_data = W'(13'h00FF) | (W'(8'h40) << 13);
                check("one_byte_data", 64'(pkt_data), 64'(exp_data));
            end
            wait_done("one_byte_done");
        end
        check("count_max", 64'(pkt_count), 64'd15);
        send_byte(8'h7E, 1'b1, 13'h0001);
        wait_done("wrap_done");
        check("count_wrap", 64'(pkt_count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/noc_packet_injector.md
Name: noc_packet_injector

Overview:
- Clocked host-side transmitter that drives the mesh's Packet_in channel.
- Collects a byte stream (filter/ifmap data) from a valid/ready source, together with a 13-bit routing header, into packets of 13 + 5*FILTER_WIDTH bits.
- Launches each packet with a 4-phase bundled-data req/ack handshake toward the node-12 router North input.
- Sits between the host/testbench memory loader and the mesh.

Parameters:
- FILTER_WIDTH, 8, bits per payload byte.
- SLOTS, 5, payload bytes per packet (fixed at 5 to match mesh packet format).
- WIDTH, 13 + SLOTS*FILTER_WIDTH, packet width (53 at defaults).
- CNT_WIDTH, 16, width of sent-packet counter.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- s_valid, input, 1, source byte valid.
- s_ready, output, 1, block accepts byte this cycle.
- s_data, input, FILTER_WIDTH, payload byte.
- s_last, input, 1, byte is last of the current packet (forces partial send).
- s_hdr, input, 13, header: [1:0] direction, [3:2] pkt_type, [6:4] x_hop, [9:7] y_hop, [12:10] tag; sampled with the slot-0 byte.
- pkt_req, output, 1, 4-phase request to mesh.
- pkt_data, output, WIDTH, packet: [12:0] header, slot k at [13+k*FILTER_WIDTH +: FILTER_WIDTH].
- pkt_ack, input, 1, 4-phase acknowledge from mesh (may be asynchronous).
- busy, output, 1, high in any state except FILL with cnt==0.
- pkt_count, output, CNT_WIDTH, packets completed (wraps).

Behaviour:
- Reset values:
  - pkt_req=0, pkt_data=0, pkt_count=0, cnt=0, s_ready=0.
  - busy=1 (REL is not FILL).
  - state=REL: reset lands in REL so a stale high ack is drained before the first request.
- States:
  - FILL: s_ready=1. On s_valid&s_ready, write s_data into slot cnt. When cnt==0, also latch s_hdr into [12:0] and zero slots 1..4. If cnt==SLOTS-1 or s_last, go to REQ and set pkt_req=1 at that same edge (1-cycle latency from the accepting edge). Otherwise cnt++.
  - REQ: s_ready=0, pkt_req=1. When ack_s==1, go to REL with pkt_req=0 registered at that edge.
  - REL: s_ready=0, pkt_req=0. When ack_s==0, go to FILL, cnt=0, and increment pkt_count (not on the post-reset pass).
- pkt_data is stable from the rise of pkt_req until REL exits. Payload bytes beyond a partial (s_last) fill are 0.
- s_ready is decoded combinationally from state.
- s_last with cnt==0 produces a one-byte packet.
- A pkt_ack change in FILL is ignored; the handshake is evaluated only in REQ/REL.
- pkt_count wraps 2^CNT_WIDTH-1 -> 0.
- Reset mid-handshake: pkt_req drops the cycle after rst is sampled, the partial packet is discarded, and the block returns to REL.
- No combinational path from pkt_ack to any output.
- Minimum packet period is SLOTS + 2 + 2*sync_latency cycles.

Optional Feature:
- Macro INJECTOR_ACK_SYNC_EN.
- Defined: ack_s = pkt_ack through a 2-flop synchronizer, reset to 0. Adds 2 cycles to each handshake phase.
- Undefined: ack_s = pkt_ack directly; the mesh must be clocked by clk.

Test Plan (ack responder = 2-cycle delayed echo of pkt_req unless stated):
- Reset with pkt_ack held 1 for 5 cycles, then drop it -> s_ready stays 0 until ack_s low, rises the cycle after; pkt_req never asserts; pkt_count=0.
- Bytes 0x11,0x22,0x33,0x44,0x55 with s_hdr=0x0A5 -> after 1 cycle pkt_req=1, pkt_data[12:0]=0x0A5, pkt_data[52:13]=0x5544332211; pkt_count=1 after release.
- Bytes 0xAA,0xBB with s_last on 0xBB, hdr=0x1F0 -> pkt_data=0x1F0 | (0xBBAA<<13), slots 2-4 zero.
- Responder holds ack low 20 cycles -> pkt_req and pkt_data stable for all 20, s_ready=0 throughout.
- rst asserted while in REQ -> pkt_req=0 next cycle, pkt_count unchanged, following packet is correct.
- pkt_count preloaded by sending 65535 packets, then one more -> pkt_count wraps to 0.
